snitch_narrow_axi_responder: RTL and testbench

Synthesizable AXI4 subordinate on the cluster's narrow port, the responder end for the narrow initiator traffic the testbench drives (entry-point write to scratch, cluster-CLINT set). It holds a small scratch register file plus cluster-CLINT set/clear registers and drives per-core software-interrupt lines. It serves as a standalone peripheral model and as a DUT for the narrow bench.

---
 rtl/snitch_narrow_axi_responder_pkg.sv | 99 +++++++++
 rtl/snitch_narrow_axi_responder_if.sv | 11 +
 rtl/snitch_narrow_axi_regfile.sv | 70 +++++++
 rtl/snitch_narrow_axi_responder.sv | 181 ++++++++++++++++++
 tb/tb_snitch_narrow_axi_responder.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snitch_narrow_axi_responder_pkg.sv
// rtl/snitch_narrow_axi_responder_pkg.sv - shared types, constants and address decode for the narrow AXI responder
package snitch_narrow_axi_responder_pkg;

  localparam int unsigned AddrWidth = 48;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 2;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned RegShift  = $clog2(StrbWidth);
  localparam int unsigned IdxWidth  = 8;

  // CLINT registers sit directly above the scratch block
  localparam int unsigned ScratchBaseIdx = 0;
  localparam int unsigned ClintSetOfs    = 0;
  localparam int unsigned ClintClrOfs    = 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {REG_SCRATCH, REG_CLINT_SET, REG_CLINT_CLR, REG_NONE} reg_kind_e;

  typedef struct packed {
    logic                err;
    reg_kind_e           kind;
    logic [IdxWidth-1:0] idx;
  } reg_decode_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } axi_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } axi_w_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } axi_b_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   ar_ready;
    logic   r_valid;
    axi_r_t r;
  } rsp_t;

  function automatic reg_decode_t decode_addr(input logic [AddrWidth-1:0] addr,
                                              input logic [2:0]           size,
                                              input logic [AddrWidth-1:0] base,
                                              input int                   num_scratch);
    reg_decode_t          d;
    logic [AddrWidth-1:0] idx_full;
    logic [AddrWidth-1:0] set_idx;
    logic [AddrWidth-1:0] clr_idx;
    idx_full = (addr - base) >> RegShift;
    set_idx  = AddrWidth'(num_scratch) + AddrWidth'(ClintSetOfs);
    clr_idx  = AddrWidth'(num_scratch) + AddrWidth'(ClintClrOfs);
    d.err    = (addr < base) || (size > 3'(RegShift)) || (idx_full > clr_idx);
    d.idx    = idx_full[IdxWidth-1:0];
    if (d.err)                  d.kind = REG_NONE;
    else if (idx_full < set_idx) d.kind = REG_SCRATCH;
    else if (idx_full == set_idx) d.kind = REG_CLINT_SET;
    else                         d.kind = REG_CLINT_CLR;
    return d;
  endfunction

endpackage

// File: rtl/snitch_narrow_axi_responder_if.sv
// rtl/snitch_narrow_axi_responder_if.sv - narrow AXI request/response bundle with initiator and responder views
interface snitch_narrow_axi_responder_if;
  import snitch_narrow_axi_responder_pkg::*;

  req_t req;
  rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/snitch_narrow_axi_regfile.sv
// rtl/snitch_narrow_axi_regfile.sv - scratch registers and msip set/clear storage with byte-strobe merge
module snitch_narrow_axi_regfile
  import snitch_narrow_axi_responder_pkg::*;
#(
  parameter int NumScratch = 4,
  parameter int NrCores    = 9
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 wr_en,
  input  reg_decode_t                          wr_dec,
  input  logic [DataWidth-1:0]                 wr_data,
  input  logic [StrbWidth-1:0]                 wr_strb,
  input  reg_decode_t                          rd_dec,
  output logic [DataWidth-1:0]                 rd_data,
  output logic [NrCores-1:0]                   msip,
  output logic [NumScratch-1:0][DataWidth-1:0] scratch
);

  logic [NumScratch-1:0][DataWidth-1:0] scratch_q;
  logic [NrCores-1:0]                   msip_q;
  logic [DataWidth-1:0]                 wr_mask;
  logic [DataWidth-1:0]                 wr_bits;

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      wr_mask[8*i +: 8] = {8{wr_strb[i]}};
    end
    wr_bits = wr_data & wr_mask;
  end

  // Unstrobed bytes of CLINT writes are masked out, so they neither set nor clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scratch_q <= '0;
      msip_q    <= '0;
    end else if (wr_en) begin
      case (wr_dec.kind)
        REG_SCRATCH: begin
          for (int i = 0; i < NumScratch; i++) begin
            if (wr_dec.idx == IdxWidth'(i)) begin
              scratch_q[i] <= (scratch_q[i] & ~wr_mask) | wr_bits;
            end
          end
        end
        REG_CLINT_SET: msip_q <= msip_q | wr_bits[NrCores-1:0];
        REG_CLINT_CLR: msip_q <= msip_q & ~wr_bits[NrCores-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_dec.kind)
      REG_SCRATCH: begin
        for (int i = 0; i < NumScratch; i++) begin
          if (rd_dec.idx == IdxWidth'(i)) rd_data = scratch_q[i];
        end
      end
      REG_CLINT_SET, REG_CLINT_CLR: rd_data = DataWidth'(msip_q);
      default: rd_data = '0;
    endcase
  end

  assign msip    = msip_q;
  assign scratch = scratch_q;

endmodule

// File: rtl/snitch_narrow_axi_responder.sv
// rtl/snitch_narrow_axi_responder.sv - narrow AXI4 responder: independent write/read FSMs over the scratch/CLINT regfile
module snitch_narrow_axi_responder
  import snitch_narrow_axi_responder_pkg::*;
#(
  parameter int                   NumScratch = 4,
  parameter int                   NrCores    = 9,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  snitch_narrow_axi_responder_if.slave         axi,
  output logic [NrCores-1:0]                   msip_o,
  output logic [NumScratch-1:0][DataWidth-1:0] scratch_o
);

  w_state_e             w_state;
  logic [AddrWidth-1:0] w_addr_q;
  logic [2:0]           w_size_q;
  logic [1:0]           w_burst_q;
  logic [7:0]           w_cnt_q;
  logic                 w_err_q;
  logic [IdWidth-1:0]   b_id_q;
  logic [1:0]           b_resp_q;

  r_state_e             r_state;
  logic [AddrWidth-1:0] r_addr_q;
  logic [2:0]           r_size_q;
  logic [1:0]           r_burst_q;
  logic [7:0]           r_cnt_q;
  logic [IdWidth-1:0]   r_id_q;
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  logic                 r_last_q;

  rsp_t                 rsp;
  reg_decode_t          w_dec;
  reg_decode_t          rd_dec;
  logic [AddrWidth-1:0] w_next_addr;
  logic [AddrWidth-1:0] r_next_addr;
  logic [AddrWidth-1:0] rd_addr;
  logic [2:0]           rd_size;
  logic                 w_beat;
  logic                 wr_en;
  logic [DataWidth-1:0] rd_data;
  logic                 unused_w_last;

  // Burst length comes from the latched len; the W last flag carries no meaning here
  assign unused_w_last = axi.req.w.last;

  assign w_next_addr = (w_burst_q == BurstFixed) ? w_addr_q : w_addr_q + AddrWidth'(StrbWidth);
  assign r_next_addr = (r_burst_q == BurstFixed) ? r_addr_q : r_addr_q + AddrWidth'(StrbWidth);
  assign w_dec       = decode_addr(w_addr_q, w_size_q, BaseAddr, NumScratch);
  assign w_beat      = (w_state == W_DATA) && axi.req.w_valid;
  assign wr_en       = w_beat && !w_dec.err;

  // Read port looks ahead at the beat that will be loaded next, so r payload is a register
  assign rd_addr = (r_state == R_IDLE) ? axi.req.ar.addr : r_next_addr;
  assign rd_size = (r_state == R_IDLE) ? axi.req.ar.size : r_size_q;
  assign rd_dec  = decode_addr(rd_addr, rd_size, BaseAddr, NumScratch);

  snitch_narrow_axi_regfile #(
    .NumScratch(NumScratch),
    .NrCores   (NrCores)
  ) i_regfile (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (wr_en),
    .wr_dec (w_dec),
    .wr_data(axi.req.w.data),
    .wr_strb(axi.req.w.strb),
    .rd_dec (rd_dec),
    .rd_data(rd_data),
    .msip   (msip_o),
    .scratch(scratch_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      w_addr_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_id_q    <= '0;
      b_resp_q  <= RespOkay;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi.req.aw_valid) begin
            w_addr_q  <= axi.req.aw.addr;
            w_size_q  <= axi.req.aw.size;
            w_burst_q <= axi.req.aw.burst;
            w_cnt_q   <= axi.req.aw.len;
            w_err_q   <= 1'b0;
            b_id_q    <= axi.req.aw.id;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_err_q  <= w_err_q | w_dec.err;
            w_addr_q <= w_next_addr;
            w_cnt_q  <= w_cnt_q - 8'd1;
            if (w_cnt_q == 8'd0) begin
              b_resp_q <= (w_err_q || w_dec.err) ? RespSlvErr : RespOkay;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.req.b_ready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= R_IDLE;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_id_q    <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
      r_last_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi.req.ar_valid) begin
            r_addr_q  <= axi.req.ar.addr;
            r_size_q  <= axi.req.ar.size;
            r_burst_q <= axi.req.ar.burst;
            r_cnt_q   <= axi.req.ar.len;
            r_id_q    <= axi.req.ar.id;
            r_data_q  <= rd_data;
            r_resp_q  <= rd_dec.err ? RespSlvErr : RespOkay;
            r_last_q  <= (axi.req.ar.len == 8'd0);
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.req.r_ready) begin
            if (r_last_q) begin
              r_state <= R_IDLE;
            end else begin
              r_addr_q <= r_next_addr;
              r_cnt_q  <= r_cnt_q - 8'd1;
              r_data_q <= rd_data;
              r_resp_q <= rd_dec.err ? RespSlvErr : RespOkay;
              r_last_q <= (r_cnt_q == 8'd1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Address readies are forced low while reset is held, since the FSMs already sit in IDLE
  always_comb begin
    rsp          = '0;
    rsp.aw_ready = (w_state == W_IDLE) && !rst_i;
    rsp.w_ready  = (w_state == W_DATA);
    rsp.b_valid  = (w_state == W_RESP);
    rsp.b.id     = b_id_q;
    rsp.b.resp   = b_resp_q;
    rsp.ar_ready = (r_state == R_IDLE) && !rst_i;
    rsp.r_valid  = (r_state == R_DATA);
    rsp.r.id     = r_id_q;
    rsp.r.data   = r_data_q;
    rsp.r.resp   = r_resp_q;
    rsp.r.last   = r_last_q;
  end

  assign axi.rsp = rsp;

endmodule

// File: tb/tb_snitch_narrow_axi_responder.sv
// tb/tb_snitch_narrow_axi_responder.sv - directed self-checking bench for the narrow AXI responder
module tb_snitch_narrow_axi_responder;
  import snitch_narrow_axi_responder_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [8:0]          msip;
  logic [3:0][63:0]    scratch;
  int                  checks = 0;
  int                  failures = 0;

  snitch_narrow_axi_responder_if bus ();

  snitch_narrow_axi_responder #(
    .NumScratch(4),
    .NrCores   (9),
    .BaseAddr  (48'h0)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .axi      (bus),
    .msip_o   (msip),
    .scratch_o(scratch)
  );

  always #5 clk = ~clk;

  task automatic aw_send(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [1:0] id);
    int n = 0;
    bus.req.aw.addr  = addr;
    bus.req.aw.len   = len;
    bus.req.aw.size  = size;
    bus.req.aw.burst = burst;
    bus.req.aw.id    = id;
    bus.req.aw_valid = 1'b1;
    while (!bus.rsp.aw_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.rsp.aw_ready) begin failures++; $display("FAIL aw_timeout: aw_ready=%b required 1", bus.rsp.aw_ready); end
    @(negedge clk);
    bus.req.aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [1:0] id);
    int n = 0;
    bus.req.ar.addr  = addr;
    bus.req.ar.len   = len;
    bus.req.ar.size  = size;
    bus.req.ar.burst = burst;
    bus.req.ar.id    = id;
    bus.req.ar_valid = 1'b1;
    while (!bus.rsp.ar_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.rsp.ar_ready) begin failures++; $display("FAIL ar_timeout: ar_ready=%b required 1", bus.rsp.ar_ready); end
    @(negedge clk);
    bus.req.ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb);
    int n = 0;
    bus.req.w.data  = data;
    bus.req.w.strb  = strb;
    bus.req.w.last  = 1'b0;
    bus.req.w_valid = 1'b1;
    while (!bus.rsp.w_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.rsp.w_ready) begin failures++; $display("FAIL w_timeout: w_ready=%b required 1", bus.rsp.w_ready); end
    @(negedge clk);
    bus.req.w_valid = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic [1:0] id);
    int n = 0;
    bus.req.b_ready = 1'b1;
    while (!bus.rsp.b_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.rsp.b_valid) begin failures++; $display("FAIL b_timeout: b_valid=%b required 1", bus.rsp.b_valid); end
    resp = bus.rsp.b.resp;
    id   = bus.rsp.b.id;
    @(negedge clk);
    bus.req.b_ready = 1'b0;
  endtask

  task automatic r_recv(output logic [63:0] data, output logic [1:0] resp, output logic last);
    int n = 0;
    bus.req.r_ready = 1'b1;
    while (!bus.rsp.r_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.rsp.r_valid) begin failures++; $display("FAIL r_timeout: r_valid=%b required 1", bus.rsp.r_valid); end
    data = bus.rsp.r.data;
    resp = bus.rsp.r.resp;
    last = bus.rsp.r.last;
    @(negedge clk);
    bus.req.r_ready = 1'b0;
  endtask

  task automatic do_write(input logic [47:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input logic [2:0] size, output logic [1:0] resp);
    logic [1:0] id;
    aw_send(addr, 8'd0, size, BurstIncr, 2'd0);
    w_send(data, strb);
    b_recv(resp, id);
  endtask

  task automatic do_read(input logic [47:0] addr, input logic [2:0] size,
                         output logic [63:0] data, output logic [1:0] resp);
    logic last;
    ar_send(addr, 8'd0, size, BurstIncr, 2'd0);
    r_recv(data, resp, last);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.rsp.aw_ready, bus.rsp.w_ready, bus.rsp.b_valid, bus.rsp.ar_ready, bus.rsp.r_valid} !== 5'b0)
      begin failures++; $display("FAIL reset_handshake: got %b required 00000",
        {bus.rsp.aw_ready, bus.rsp.w_ready, bus.rsp.b_valid, bus.rsp.ar_ready, bus.rsp.r_valid}); end
    checks++;
    if (msip !== 9'h0 || scratch !== '0)
      begin failures++; $display("FAIL reset_regs: msip=%h scratch=%h required 0", msip, scratch); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rsp.aw_ready !== 1'b1 || bus.rsp.ar_ready !== 1'b1)
      begin failures++; $display("FAIL release_ready: aw=%b ar=%b required 1 1", bus.rsp.aw_ready, bus.rsp.ar_ready); end
    @(negedge clk);
  endtask

  task automatic test_scratch_rw();
    logic [1:0] resp, id;
    logic [63:0] data;
    logic last;
    aw_send(48'h8, 8'd0, 3'd3, BurstIncr, 2'd2);
    checks++;
    if (bus.rsp.w_ready !== 1'b1 || bus.rsp.b_valid !== 1'b0)
      begin failures++; $display("FAIL w_ready_after_aw: w_ready=%b b_valid=%b required 1 0", bus.rsp.w_ready, bus.rsp.b_valid); end
    w_send(64'hDEAD_BEEF, 8'hFF);
    checks++;
    if (bus.rsp.b_valid !== 1'b1)
      begin failures++; $display("FAIL b_latency: b_valid=%b required 1", bus.rsp.b_valid); end
    checks++;
    if (scratch[1] !== 64'hDEAD_BEEF)
      begin failures++; $display("FAIL scratch1_out: got %h required deadbeef", scratch[1]); end
    b_recv(resp, id);
    checks++;
    if (resp !== RespOkay || id !== 2'd2)
      begin failures++; $display("FAIL scratch_b: resp=%h id=%h required 0 2", resp, id); end
    ar_send(48'h8, 8'd0, 3'd3, BurstIncr, 2'd1);
    checks++;
    if (bus.rsp.r_valid !== 1'b1 || bus.rsp.r.id !== 2'd1)
      begin failures++; $display("FAIL r_latency: r_valid=%b id=%h required 1 1", bus.rsp.r_valid, bus.rsp.r.id); end
    r_recv(data, resp, last);
    checks++;
    if (data !== 64'hDEAD_BEEF || resp !== RespOkay || last !== 1'b1)
      begin failures++; $display("FAIL scratch_read: data=%h resp=%h last=%b required deadbeef 0 1", data, resp, last); end
  endtask

  task automatic test_clint();
    logic [1:0] resp, id;
    logic [63:0] data;
    aw_send(48'h20, 8'd0, 3'd3, BurstIncr, 2'd0);
    w_send(64'h1FF, 8'hFF);
    checks++;
    if (msip !== 9'h1FF) begin failures++; $display("FAIL clint_set: msip=%h required 1ff", msip); end
    b_recv(resp, id);
    do_write(48'h28, 64'h5, 8'hFF, 3'd3, resp);
    checks++;
    if (msip !== 9'h1FA || resp !== RespOkay)
      begin failures++; $display("FAIL clint_clr: msip=%h resp=%h required 1fa 0", msip, resp); end
    do_read(48'h20, 3'd3, data, resp);
    checks++;
    if (data !== 64'h1FA || resp !== RespOkay)
      begin failures++; $display("FAIL clint_set_read: data=%h resp=%h required 1fa 0", data, resp); end
    do_read(48'h28, 3'd3, data, resp);
    checks++;
    if (data !== 64'h1FA) begin failures++; $display("FAIL clint_clr_read: data=%h required 1fa", data); end
    // SET then CLR as consecutive beats of one INCR burst: 1fa|00f=1ff, then &~003 = 1fc
    aw_send(48'h20, 8'd1, 3'd3, BurstIncr, 2'd0);
    w_send(64'hF, 8'hFF);
    w_send(64'h3, 8'hFF);
    b_recv(resp, id);
    checks++;
    if (msip !== 9'h1FC || resp !== RespOkay)
      begin failures++; $display("FAIL clint_order: msip=%h resp=%h required 1fc 0", msip, resp); end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp, id;
    logic [63:0] d0;
    logic [63:0] expv;
    aw_send(48'h0, 8'd3, 3'd3, BurstIncr, 2'd3);
    for (int k = 0; k < 4; k++) w_send(64'(k + 1), 8'hFF);
    b_recv(resp, id);
    checks++;
    if (resp !== RespOkay || id !== 2'd3)
      begin failures++; $display("FAIL burst_b: resp=%h id=%h required 0 3", resp, id); end
    checks++;
    if (scratch !== {64'd4, 64'd3, 64'd2, 64'd1})
      begin failures++; $display("FAIL burst_scratch: got %h required 4,3,2,1", scratch); end
    ar_send(48'h0, 8'd3, 3'd3, BurstIncr, 2'd3);
    for (int k = 0; k < 4; k++) begin
      expv = 64'(k + 1);
      bus.req.r_ready = 1'b0;
      d0 = bus.rsp.r.data;
      @(negedge clk);
      checks++;
      if (bus.rsp.r_valid !== 1'b1 || d0 !== expv || bus.rsp.r.data !== expv ||
          bus.rsp.r.last !== (k == 3) || bus.rsp.r.resp !== RespOkay)
        begin failures++; $display("FAIL burst_beat%0d: valid=%b before=%h after=%h last=%b required 1 %h %h %b",
          k, bus.rsp.r_valid, d0, bus.rsp.r.data, bus.rsp.r.last, expv, expv, k == 3); end
      bus.req.r_ready = 1'b1;
      @(negedge clk);
    end
    bus.req.r_ready = 1'b0;
    checks++;
    if (bus.rsp.r_valid !== 1'b0) begin failures++; $display("FAIL burst_end: r_valid=%b required 0", bus.rsp.r_valid); end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [63:0] data;
    do_write(48'h48, 64'hAAAA, 8'hFF, 3'd3, resp);
    checks++;
    if (resp !== RespSlvErr) begin failures++; $display("FAIL oor_write: resp=%h required 2", resp); end
    checks++;
    if (scratch !== {64'd4, 64'd3, 64'd2, 64'd1} || msip !== 9'h1FC)
      begin failures++; $display("FAIL oor_nochange: scratch=%h msip=%h required 4,3,2,1 1fc", scratch, msip); end
    do_read(48'h48, 3'd3, data, resp);
    checks++;
    if (resp !== RespSlvErr || data !== 64'h0)
      begin failures++; $display("FAIL oor_read: data=%h resp=%h required 0 2", data, resp); end
    do_read(48'h0, 3'd4, data, resp);
    checks++;
    if (resp !== RespSlvErr || data !== 64'h0)
      begin failures++; $display("FAIL size_read: data=%h resp=%h required 0 2", data, resp); end
    do_write(48'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'd4, resp);
    checks++;
    if (resp !== RespSlvErr || scratch[0] !== 64'd1)
      begin failures++; $display("FAIL size_write: resp=%h scratch0=%h required 2 1", resp, scratch[0]); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [63:0] data;
    do_write(48'h0, 64'h0, 8'hFF, 3'd3, resp);
    do_write(48'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 3'd3, resp);
    do_read(48'h0, 3'd3, data, resp);
    checks++;
    if (data !== 64'h0000_0000_FFFF_FFFF || resp !== RespOkay)
      begin failures++; $display("FAIL strobe_read: data=%h resp=%h required 00000000ffffffff 0", data, resp); end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp, id;
    logic [63:0] data;
    logic seen_b = 1'b0;
    aw_send(48'h0, 8'd3, 3'd3, BurstIncr, 2'd1);
    w_send(64'h55, 8'hFF);
    w_send(64'h66, 8'hFF);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp.aw_ready, bus.rsp.w_ready, bus.rsp.b_valid, bus.rsp.ar_ready, bus.rsp.r_valid} !== 5'b0 ||
        scratch !== '0 || msip !== 9'h0)
      begin failures++; $display("FAIL midburst_reset: hs=%b scratch=%h msip=%h required 0 0 0",
        {bus.rsp.aw_ready, bus.rsp.w_ready, bus.rsp.b_valid, bus.rsp.ar_ready, bus.rsp.r_valid}, scratch, msip); end
    @(negedge clk);
    rst = 1'b0;
    bus.req.b_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seen_b = seen_b | bus.rsp.b_valid;
      @(negedge clk);
    end
    bus.req.b_ready = 1'b0;
    checks++;
    if (seen_b !== 1'b0) begin failures++; $display("FAIL midburst_no_b: b_valid seen=%b required 0", seen_b); end
    do_write(48'h10, 64'h1234, 8'hFF, 3'd3, resp);
    checks++;
    if (resp !== RespOkay || scratch[2] !== 64'h1234)
      begin failures++; $display("FAIL post_reset_write: resp=%h scratch2=%h required 0 1234", resp, scratch[2]); end
    do_read(48'h10, 3'd3, data, resp);
    checks++;
    if (data !== 64'h1234 || resp !== RespOkay)
      begin failures++; $display("FAIL post_reset_read: data=%h resp=%h required 1234 0", data, resp); end
  endtask

  initial begin
    bus.req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_scratch_rw();
    test_clint();
    test_incr_burst();
    test_errors();
    test_strobe();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
